// File: rtl/hamming74_rx_deframer.sv
// Hamming(7,4) receive deframer: serial bits -> 7-bit codeword -> corrected 4-bit data, 1 cycle after the 7th bit.
// No input backpressure: a word completing while the output register is held is dropped and overflow pulses.
module hamming74_rx_deframer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             framing_err,
  output logic [CNT_W-1:0] corr_count,
  input  logic             clr_count
);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syndrome;
    logic       corrected;
  } dec_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] sr;
  dec_t       out_q;

  logic [6:0] word;
  logic [6:0] fixed;
  logic [2:0] syn;
  logic       done;
  logic       accept;
  dec_t       dec;

  // Word as it will look once the current bit is shifted in.
  assign word = {sr[5:0], bit_in};
  assign done = bit_valid && !sof && (state == COLLECT) && (bit_cnt == 3'd6);

  assign syn[0] = word[0] ^ word[2] ^ word[4] ^ word[6];
  assign syn[1] = word[1] ^ word[2] ^ word[5] ^ word[6];
  assign syn[2] = word[3] ^ word[4] ^ word[5] ^ word[6];

  // The syndrome equals the 1-based position of the erroneous bit.
  always_comb begin
    fixed = word;
    if (syn != 3'd0) begin
      fixed[syn - 3'd1] = ~word[syn - 3'd1];
    end
  end

  always_comb begin
    dec           = '0;
    dec.data      = {fixed[6], fixed[5], fixed[4], fixed[2]};
    dec.syndrome  = syn;
    dec.corrected = (syn != 3'd0);
  end

  assign accept = done && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      bit_cnt     <= 3'd0;
      sr          <= 7'd0;
      out_q       <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      framing_err <= 1'b0;
      corr_count  <= '0;
    end else begin
      overflow    <= done && !accept;
      framing_err <= bit_valid && sof && (state == COLLECT) && (bit_cnt != 3'd0);

      if (bit_valid) begin
        sr <= word;
        if (sof) begin
          state   <= COLLECT;
          bit_cnt <= 3'd1;
        end else if (state == COLLECT) begin
          bit_cnt <= (bit_cnt == 3'd6) ? 3'd0 : bit_cnt + 3'd1;
        end
      end

      if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (clr_count) begin
        corr_count <= '0;
      end else if (accept && dec.corrected && !(&corr_count)) begin
        corr_count <= corr_count + CNT_W'(1);
      end
    end
  end

  assign out_data      = out_q.data;
  assign out_syndrome  = out_q.syndrome;
  assign out_corrected = out_q.corrected;

endmodule

// File: tb/tb_hamming74_rx_deframer.sv
// Scoreboard bench for hamming74_rx_deframer with a small-counter second instance for saturation.
module tb_hamming74_rx_deframer;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        sof;
  logic        out_ready;
  logic        clr_count;
  logic [3:0]  out_data;
  logic [2:0]  out_syndrome;
  logic        out_corrected;
  logic        out_valid;
  logic        overflow;
  logic        framing_err;
  logic [15:0] corr_count;

  logic [3:0]  s_data;
  logic [2:0]  s_syndrome;
  logic        s_corrected;
  logic        s_valid;
  logic        s_overflow;
  logic        s_framing_err;
  logic [1:0]  s_corr_count;

  int   vectors;
  int   miscompares;
  int   ovf_cnt;
  int   fe_cnt;
  exp_t exp_q[$];

  hamming74_rx_deframer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .framing_err(framing_err), .corr_count(corr_count), .clr_count(clr_count)
  );

  hamming74_rx_deframer #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .out_data(s_data), .out_syndrome(s_syndrome), .out_corrected(s_corrected),
    .out_valid(s_valid), .out_ready(out_ready), .overflow(s_overflow),
    .framing_err(s_framing_err), .corr_count(s_corr_count), .clr_count(clr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder straight from the parity equations.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // flip = 0: clean word; flip = 1..7: bit at 1-based position flip is inverted.
  function automatic logic [6:0] corrupt(input logic [6:0] code, input int flip);
    logic [6:0] c;
    c = code;
    if (flip != 0) c[flip-1] = ~c[flip-1];
    return c;
  endfunction

  function automatic exp_t expect_for(input logic [3:0] d, input int flip);
    exp_t e;
    e.data = d;
    e.syn  = 3'(flip);
    e.corr = (flip != 0);
    return e;
  endfunction

  task automatic drive_bit(input logic b, input logic s);
    @(posedge clk); #1;
    bit_in = b; sof = s; bit_valid = 1'b1;
  endtask

  // Idle cycle with junk on bit_in/sof that must be ignored.
  task automatic idle();
    @(posedge clk); #1;
    bit_valid = 1'b0; bit_in = 1'($urandom); sof = 1'($urandom);
  endtask

  task automatic send_word(input logic [6:0] code, input bit gaps);
    for (int i = 6; i >= 0; i--) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle();
      drive_bit(code[i], i == 6);
    end
  endtask

  task automatic send_raw(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'($urandom), 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid_low", 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clr_count = 1'b1; bit_valid = 1'b0;
    @(posedge clk); #1; clr_count = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (overflow === 1'b1) ovf_cnt++;
      if (framing_err === 1'b1) fe_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got data=%h syn=%h, expected no word", out_data, out_syndrome);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
          check("out_corrected", 32'(out_corrected), 32'(e.corr));
        end
      end
    end
  end

  initial begin
    logic [3:0] d;
    int         ovf0;
    int         fe0;
    vectors = 0; miscompares = 0; ovf_cnt = 0; fe_cnt = 0;
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
    out_ready = 1'b1; clr_count = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_syndrome", 32'(out_syndrome), 32'd0);
    check("rst_out_corrected", 32'(out_corrected), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_framing_err", 32'(framing_err), 32'd0);
    check("rst_corr_count", 32'(corr_count), 32'd0);
    rst_n = 1'b1;

    // Bits before any sof are discarded
    send_raw(9);
    idle(); idle();
    check("hunt_no_output", 32'(out_valid), 32'd0);

    // Clean word 1010 with latency check
    exp_q.push_back(expect_for(4'b1010, 0));
    send_word(7'b1010010, 1'b0);
    check("t1_not_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    bit_valid = 1'b0;
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    drain();
    check("t1_corr_count", 32'(corr_count), 32'd0);

    // Single flip on c2
    exp_q.push_back(expect_for(4'b1010, 3));
    send_word(7'b1010110, 1'b1);
    drain();
    check("t2_corr_count", 32'(corr_count), 32'd1);

    // Exhaustive: 16 data values x {clean, 7 flips}
    pulse_clear();
    check("clr_corr_count", 32'(corr_count), 32'd0);
    ovf0 = ovf_cnt; fe0 = fe_cnt;
    for (int v = 0; v < 16; v++) begin
      for (int f = 0; f < 8; f++) begin
        d = 4'(v);
        exp_q.push_back(expect_for(d, f));
        send_word(corrupt(encode(d), f), 1'b1);
      end
    end
    drain();
    check("t3_corr_count", 32'(corr_count), 32'd112);
    check("t3_no_overflow", 32'(ovf_cnt - ovf0), 32'd0);
    check("t3_no_framing_err", 32'(fe_cnt - fe0), 32'd0);
    check("small_cnt_saturated", 32'(s_corr_count), 32'd3);

    // Output held: second back-to-back word is dropped
    out_ready = 1'b0;
    ovf0 = ovf_cnt;
    d = 4'($urandom);
    exp_q.push_back(expect_for(d, 0));
    send_word(encode(d), 1'b0);
    send_word(corrupt(encode(~d), 5), 1'b0);
    idle(); idle(); idle();
    check("t4_held_valid", 32'(out_valid), 32'd1);
    check("t4_held_data", 32'(out_data), 32'(d));
    check("t4_held_syndrome", 32'(out_syndrome), 32'd0);
    check("t4_overflow_once", 32'(ovf_cnt - ovf0), 32'd1);
    check("t4_corr_unchanged", 32'(corr_count), 32'd112);
    @(posedge clk); #1; out_ready = 1'b1;
    drain();

    // Framing error: sof after 3 bits, then a good word
    fe0 = fe_cnt;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    d = 4'($urandom);
    exp_q.push_back(expect_for(d, 0));
    send_word(encode(d), 1'b0);
    drain();
    check("t5_framing_err_once", 32'(fe_cnt - fe0), 32'd1);
    check("t5_corr_count", 32'(corr_count), 32'd112);

    // Clear of a saturated 2-bit counter
    check("t6_small_before_clr", 32'(s_corr_count), 32'd3);
    pulse_clear();
    check("t6_small_after_clr", 32'(s_corr_count), 32'd0);
    check("t6_corr_after_clr", 32'(corr_count), 32'd0);

    // Reset mid-word while out_valid=1
    out_ready = 1'b0;
    send_word(corrupt(encode(4'($urandom)), 2), 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    @(posedge clk); #1;
    check("t6_valid_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0; bit_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_out_data", 32'(out_data), 32'd0);
    check("t6_rst_out_syndrome", 32'(out_syndrome), 32'd0);
    check("t6_rst_out_corrected", 32'(out_corrected), 32'd0);
    check("t6_rst_corr_count", 32'(corr_count), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_raw(11);
    idle(); idle();
    check("t6_no_output_before_sof", 32'(out_valid), 32'd0);
    d = 4'($urandom);
    exp_q.push_back(expect_for(d, 7));
    send_word(corrupt(encode(d), 7), 1'b1);
    drain();
    check("t6_corr_after_restart", 32'(corr_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
